// File: rtl/input_flow_ctrl_pkg.sv
// Shared FSM encoding, blocking-mode constants and counter helper for input_flow_ctrl.
package input_flow_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACTIVE = 2'd2
  } ifc_state_e;

  localparam int MODE_GLOBAL = 0;
  localparam int MODE_PER_VC = 1;

  localparam int CNT_W = 16;

  // Statistics counters hold at all-ones rather than wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/input_flow_ctrl_vc_dest_decode.sv
// Extracts the destination VC field of a word, range-checks it and one-hot decodes it.
module vc_dest_decode
  import input_flow_ctrl_pkg::*;
#(
  parameter int NUM_VC     = 2,
  parameter int DATA_WIDTH = 6,
  parameter int VC_LSB     = 4,
  parameter int VCW        = $clog2(NUM_VC)
) (
  input  logic [DATA_WIDTH-1:0] word_i,
  output logic                  in_range_o,
  output logic [NUM_VC-1:0]     onehot_o
);

  logic [VCW-1:0] dest;
  logic           unused_bits;

  assign dest        = word_i[VC_LSB +: VCW];
  assign unused_bits = ^word_i;
  assign in_range_o  = ({1'b0, dest} < (VCW+1)'(NUM_VC));

  // Out-of-range destinations decode to all-zero so they never push or block.
  for (genvar v = 0; v < NUM_VC; v++) begin : g_oh
    assign onehot_o[v] = in_range_o && (dest == VCW'(v));
  end

endmodule

// File: rtl/input_flow_ctrl.sv
// Moves words from the main FIFO into per-VC FIFOs, honouring VC pause flags.
// Define INPUT_FLOW_CTRL_STATS_EN to add saturating pop_count/stall_count outputs.
module input_flow_ctrl
  import input_flow_ctrl_pkg::*;
#(
  parameter int NUM_VC     = 2,
  parameter int DATA_WIDTH = 6,
  parameter int VC_LSB     = 4,
  parameter int BLOCK_MODE = MODE_GLOBAL
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic                  init,
  input  logic [DATA_WIDTH-1:0] fifo_data_main,
  input  logic                  fifo_empty_main,
  input  logic [NUM_VC-1:0]     fifo_pause_vc,
  output logic                  pop_main,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [NUM_VC-1:0]     push_vc,
  output logic                  err_dest,
  output logic                  active
`ifdef INPUT_FLOW_CTRL_STATS_EN
  ,
  output logic [CNT_W-1:0]      pop_count,
  output logic [CNT_W-1:0]      stall_count
`endif
);

  ifc_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q;
  logic [NUM_VC-1:0]     push_q;
  logic                  err_q;
  logic                  in_range;
  logic [NUM_VC-1:0]     dest_oh;
  logic                  blocked;
  logic                  pop;

  vc_dest_decode #(
    .NUM_VC    (NUM_VC),
    .DATA_WIDTH(DATA_WIDTH),
    .VC_LSB    (VC_LSB)
  ) u_dec (
    .word_i    (fifo_data_main),
    .in_range_o(in_range),
    .onehot_o  (dest_oh)
  );

  // A discarded (out-of-range) head never waits on any pause flag.
  assign blocked = (BLOCK_MODE == MODE_PER_VC) ? |(dest_oh & fifo_pause_vc)
                                               : (in_range & (|fifo_pause_vc));

  assign pop = (state_q == ST_ACTIVE) & ~fifo_empty_main & ~blocked & ~init;

  always_comb begin
    state_d = state_q;
    if (init) begin
      state_d = ST_INIT;
    end else begin
      case (state_q)
        ST_INIT:   state_d = ST_IDLE;
        ST_IDLE:   if (!fifo_empty_main) state_d = ST_ACTIVE;
        ST_ACTIVE: if (fifo_empty_main)  state_d = ST_IDLE;
        default:   state_d = ST_INIT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) state_q <= ST_INIT;
    else          state_q <= state_d;
  end

  // Push stage is not cleared by init so a word popped just before init still lands.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      data_q <= '0;
      push_q <= '0;
      err_q  <= 1'b0;
    end else begin
      push_q <= pop ? dest_oh : '0;
      err_q  <= pop & ~in_range;
      if (pop) data_q <= fifo_data_main;
    end
  end

`ifdef INPUT_FLOW_CTRL_STATS_EN
  logic [CNT_W-1:0] pop_cnt_q, stall_cnt_q;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      pop_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else if (state_q == ST_INIT) begin
      pop_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (pop) pop_cnt_q <= sat_inc(pop_cnt_q);
      if ((state_q == ST_ACTIVE) && !fifo_empty_main && blocked)
        stall_cnt_q <= sat_inc(stall_cnt_q);
    end
  end

  assign pop_count   = pop_cnt_q;
  assign stall_count = stall_cnt_q;
`endif

  assign pop_main = pop;
  assign data_out = data_q;
  assign push_vc  = push_q;
  assign err_dest = err_q;
  assign active   = (state_q == ST_ACTIVE);

endmodule
